// File: rtl/sisc_ctrl_mc.sv
// SISC multi-cycle control FSM: fetch/decode/execute/mem/writeback sequencing with registered Moore outputs.
// Optional performance counters (cyc_cnt, instr_cnt) are enabled by defining SISC_CTRL_PERF_CNT_EN.
module sisc_ctrl_mc #(
  parameter int STAT_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic [3:0]        opcode,
  input  logic [STAT_W-1:0] mm,
  input  logic [STAT_W-1:0] stat,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic              ir_load,
  output logic              pc_write,
  output logic [1:0]        pc_sel,
  output logic              rf_we,
  output logic              wb_sel,
  output logic [1:0]        alu_op,
  output logic              halted,
  output logic [2:0]        state_o
`ifdef SISC_CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  cyc_cnt,
  output logic [CNT_W-1:0]  instr_cnt
`endif
);

  localparam logic [2:0] S_RESET     = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_EXECUTE   = 3'd3;
  localparam logic [2:0] S_MEM       = 3'd4;
  localparam logic [2:0] S_WRITEBACK = 3'd5;
  localparam logic [2:0] S_HALT      = 3'd6;

  localparam logic [3:0] OP_LOD = 4'd1;
  localparam logic [3:0] OP_STR = 4'd2;
  localparam logic [3:0] OP_SWP = 4'd3;
  localparam logic [3:0] OP_BRA = 4'd4;
  localparam logic [3:0] OP_BRR = 4'd5;
  localparam logic [3:0] OP_BNE = 4'd6;
  localparam logic [3:0] OP_BNR = 4'd7;
  localparam logic [3:0] OP_ALU = 4'd8;
  localparam logic [3:0] OP_HLT = 4'd15;

  logic [2:0] state, state_n;
  logic [3:0] op_q, op_n;
  logic       mem_req_n, mem_we_n, ir_load_n, pc_write_n, rf_we_n, wb_sel_n, halted_n;
  logic [1:0] pc_sel_n, alu_op_n;
  logic       imm, hit, is_write;

  if (STAT_W == 4) begin : g_imm4
    assign imm = (mm == 4'd8);
  end else begin : g_imm
    assign imm = &mm;
  end

  assign hit      = |(stat & mm);
  assign is_write = (op_q == OP_STR) || (op_q == OP_SWP);
  assign state_o  = state;

  // Outputs are computed for the state being entered and registered with it.
  always_comb begin
    state_n    = state;
    op_n       = op_q;
    alu_op_n   = alu_op;
    mem_req_n  = 1'b0;
    mem_we_n   = 1'b0;
    ir_load_n  = 1'b0;
    pc_write_n = 1'b0;
    pc_sel_n   = 2'd0;
    rf_we_n    = 1'b0;
    wb_sel_n   = 1'b0;
    halted_n   = 1'b0;
    case (state)
      S_RESET: begin
        state_n   = S_FETCH;
        mem_req_n = 1'b1;
      end
      S_FETCH: begin
        if (mem_ack) begin
          state_n    = S_DECODE;
          ir_load_n  = 1'b1;
          pc_write_n = 1'b1;
        end else begin
          mem_req_n = 1'b1;
        end
      end
      S_DECODE: begin
        op_n     = opcode;
        alu_op_n = {imm, opcode == OP_ALU};
        if (opcode == OP_HLT) begin
          state_n  = S_HALT;
          halted_n = 1'b1;
        end else begin
          state_n = S_EXECUTE;
          // Branch resolution happens here so pc_write lands in the EXECUTE cycle.
          case (opcode)
            OP_BRA: begin pc_write_n = hit;  pc_sel_n = hit  ? 2'd1 : 2'd0; end
            OP_BRR: begin pc_write_n = hit;  pc_sel_n = hit  ? 2'd2 : 2'd0; end
            OP_BNE: begin pc_write_n = !hit; pc_sel_n = !hit ? 2'd1 : 2'd0; end
            OP_BNR: begin pc_write_n = !hit; pc_sel_n = !hit ? 2'd2 : 2'd0; end
            default: ;
          endcase
        end
      end
      S_EXECUTE: begin
        case (op_q)
          OP_ALU: begin
            state_n = S_WRITEBACK;
            rf_we_n = 1'b1;
          end
          OP_LOD, OP_STR, OP_SWP: begin
            state_n   = S_MEM;
            mem_req_n = 1'b1;
            mem_we_n  = is_write;
          end
          default: begin
            state_n   = S_FETCH;
            mem_req_n = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        if (mem_ack) begin
          if (op_q == OP_STR) begin
            state_n   = S_FETCH;
            mem_req_n = 1'b1;
          end else begin
            state_n  = S_WRITEBACK;
            rf_we_n  = 1'b1;
            wb_sel_n = 1'b1;
          end
        end else begin
          mem_req_n = 1'b1;
          mem_we_n  = is_write;
        end
      end
      S_WRITEBACK: begin
        state_n   = S_FETCH;
        mem_req_n = 1'b1;
      end
      S_HALT: begin
        halted_n = 1'b1;
      end
      default: state_n = S_RESET;
    endcase
  end

  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      state    <= S_RESET;
      op_q     <= '0;
      alu_op   <= '0;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      ir_load  <= 1'b0;
      pc_write <= 1'b0;
      pc_sel   <= '0;
      rf_we    <= 1'b0;
      wb_sel   <= 1'b0;
      halted   <= 1'b0;
    end else begin
      state    <= state_n;
      op_q     <= op_n;
      alu_op   <= alu_op_n;
      mem_req  <= mem_req_n;
      mem_we   <= mem_we_n;
      ir_load  <= ir_load_n;
      pc_write <= pc_write_n;
      pc_sel   <= pc_sel_n;
      rf_we    <= rf_we_n;
      wb_sel   <= wb_sel_n;
      halted   <= halted_n;
    end
  end

`ifdef SISC_CTRL_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      cyc_cnt   <= '0;
      instr_cnt <= '0;
    end else begin
      if (state != S_RESET && state != S_HALT && cyc_cnt != '1)
        cyc_cnt <= cyc_cnt + CNT_W'(1);
      if (state == S_DECODE && instr_cnt != '1)
        instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_sisc_ctrl_mc.sv
// Scoreboard bench for sisc_ctrl_mc: per-cycle expected output vectors are queued with the
// mem_ack stimulus for that cycle, then popped and compared at each falling edge.
module tb_sisc_ctrl_mc;
  localparam int STAT_W = 4;
  localparam int CNT_W  = 4;

  logic clk = 1'b0;
  logic rst_f;
  logic [3:0] opcode;
  logic [STAT_W-1:0] mm, stat;
  logic mem_ack;
  logic mem_req, mem_we, ir_load, pc_write, rf_we, wb_sel, halted;
  logic [1:0] pc_sel, alu_op;
  logic [2:0] state_o;
`ifdef SISC_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_cnt, instr_cnt;
`endif

  sisc_ctrl_mc #(.STAT_W(STAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .ir_load(ir_load), .pc_write(pc_write),
    .pc_sel(pc_sel), .rf_we(rf_we), .wb_sel(wb_sel), .alu_op(alu_op), .halted(halted),
    .state_o(state_o)
`ifdef SISC_CTRL_PERF_CNT_EN
    , .cyc_cnt(cyc_cnt), .instr_cnt(instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ack;
    logic [13:0] exp;
  } ent_t;

  ent_t sb[$];
  int n_checks = 0;
  int n_err = 0;
  logic [1:0] m_alu;
  logic [13:0] obs;

  assign obs = {state_o, alu_op, mem_req, mem_we, ir_load, pc_write, pc_sel, rf_we, wb_sel, halted};

  function automatic logic [13:0] ev(input int st, input logic [1:0] alu, input int mreq, input int mwe,
                                     input int irl, input int pcw, input int psel, input int rfwe,
                                     input int wbs, input int hlt);
    logic [2:0] s3;
    logic [1:0] p2;
    s3 = st[2:0];
    p2 = psel[1:0];
    return {s3, alu, mreq[0], mwe[0], irl[0], pcw[0], p2, rfwe[0], wbs[0], hlt[0]};
  endfunction

  task automatic push(input logic ack, input logic [13:0] e);
    sb.push_back({ack, e});
  endtask

  // Reference model: expected per-cycle outputs of one instruction starting at FETCH entry.
  task automatic push_instr(input logic [3:0] op, input logic [3:0] m, input logic [3:0] s,
                            input int fetch_wait, input int mem_wait, input logic ack_idle);
    logic [1:0] na;
    logic br, taken;
    int psel;
    for (int i = 0; i < fetch_wait; i++) push(1'b0, ev(1, m_alu, 1, 0, 0, 0, 0, 0, 0, 0));
    push(1'b1, ev(1, m_alu, 1, 0, 0, 0, 0, 0, 0, 0));
    push(ack_idle, ev(2, m_alu, 0, 0, 1, 1, 0, 0, 0, 0));
    na = {m == 4'd8, op == 4'd8};
    m_alu = na;
    if (op == 4'd15) return;
    br = op inside {[4'd4:4'd7]};
    taken = (op == 4'd4 || op == 4'd5) ? ((s & m) != 4'd0) : ((s & m) == 4'd0);
    psel = (op == 4'd5 || op == 4'd7) ? 2 : 1;
    push(ack_idle, ev(3, na, 0, 0, 0, int'(br && taken), (br && taken) ? psel : 0, 0, 0, 0));
    if (op == 4'd8) begin
      push(ack_idle, ev(5, na, 0, 0, 0, 0, 0, 1, 0, 0));
    end else if (op inside {4'd1, 4'd2, 4'd3}) begin
      for (int i = 0; i < mem_wait; i++) push(1'b0, ev(4, na, 1, int'(op != 4'd1), 0, 0, 0, 0, 0, 0));
      push(1'b1, ev(4, na, 1, int'(op != 4'd1), 0, 0, 0, 0, 0, 0));
      if (op != 4'd2) push(ack_idle, ev(5, na, 0, 0, 0, 0, 0, 1, 1, 0));
    end
  endtask

  task automatic test_reset();
    ent_t e;
    rst_f = 1'b1; opcode = 4'd0; mm = 4'd0; stat = 4'd0; mem_ack = 1'b0; m_alu = 2'b00;
    repeat (2) @(negedge clk);
    n_checks++;
    if (obs !== 14'd0) begin
      n_err++; $display("FAIL reset_outputs: got %h expected %h", obs, 14'd0);
    end
`ifdef SISC_CTRL_PERF_CNT_EN
    n_checks++;
    if (cyc_cnt !== 4'd0 || instr_cnt !== 4'd0) begin
      n_err++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", cyc_cnt, instr_cnt);
    end
`endif
    rst_f = 1'b0;
    push(1'b1, ev(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
    while (sb.size() != 0) begin
      e = sb.pop_front(); mem_ack = e.ack; n_checks++;
      if (obs !== e.exp) begin n_err++; $display("FAIL reset_exit: got %h expected %h", obs, e.exp); end
      @(negedge clk);
    end
  endtask

  task automatic test_alu();
    ent_t e;
    opcode = 4'd8; mm = 4'd0; stat = 4'd0;
    push_instr(4'd8, 4'd0, 4'd0, 0, 0, 1'b1);
    opcode = 4'd8;
    while (sb.size() != 0) begin
      e = sb.pop_front(); mem_ack = e.ack; n_checks++;
      if (obs !== e.exp) begin n_err++; $display("FAIL alu_add: got %h expected %h", obs, e.exp); end
      @(negedge clk);
    end
    mm = 4'd8;
    push_instr(4'd8, 4'd8, 4'd0, 1, 0, 1'b0);
    while (sb.size() != 0) begin
      e = sb.pop_front(); mem_ack = e.ack; n_checks++;
      if (obs !== e.exp) begin n_err++; $display("FAIL alu_imm: got %h expected %h", obs, e.exp); end
      @(negedge clk);
    end
  endtask

  task automatic test_lod_wait();
    ent_t e;
    opcode = 4'd1; mm = 4'd0; stat = 4'd0;
    push_instr(4'd1, 4'd0, 4'd0, 0, 2, 1'b0);
    while (sb.size() != 0) begin
      e = sb.pop_front(); mem_ack = e.ack; n_checks++;
      if (obs !== e.exp) begin n_err++; $display("FAIL lod_wait: got %h expected %h", obs, e.exp); end
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    ent_t e;
    logic [11:0] tbl [7];
    tbl = '{12'h622, 12'h620, 12'h431, 12'h434, 12'h544, 12'h712, 12'h711};
    for (int k = 0; k < 7; k++) begin
      opcode = tbl[k][11:8]; mm = tbl[k][7:4]; stat = tbl[k][3:0];
      push_instr(opcode, mm, stat, 0, 0, 1'(k % 2));
      while (sb.size() != 0) begin
        e = sb.pop_front(); mem_ack = e.ack; n_checks++;
        if (obs !== e.exp) begin
          n_err++; $display("FAIL branch_%0d op=%0d: got %h expected %h", k, opcode, obs, e.exp);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_back_to_back();
    ent_t e;
    logic [3:0] ops [8];
    ops = '{4'd2, 4'd3, 4'd0, 4'd11, 4'd9, 4'd14, 4'd8, 4'd1};
    for (int k = 0; k < 8; k++) begin
      opcode = ops[k]; mm = 4'($urandom_range(0, 15)); stat = 4'($urandom_range(0, 15));
      push_instr(opcode, mm, stat, k % 2, k % 3, 1'(k % 2));
      while (sb.size() != 0) begin
        e = sb.pop_front(); mem_ack = e.ack; n_checks++;
        if (obs !== e.exp) begin
          n_err++; $display("FAIL b2b_%0d op=%0d: got %h expected %h", k, opcode, obs, e.exp);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset_mid_mem();
    ent_t e;
    int n;
    opcode = 4'd1; mm = 4'd0; stat = 4'd0;
    push_instr(4'd1, 4'd0, 4'd0, 0, 5, 1'b0);
    n = 0;
    while (sb.size() != 0 && n < 5) begin
      e = sb.pop_front(); mem_ack = e.ack; n_checks++; n++;
      if (obs !== e.exp) begin n_err++; $display("FAIL mid_mem_pre: got %h expected %h", obs, e.exp); end
      @(negedge clk);
    end
    sb.delete();
    #2 rst_f = 1'b1;
    #1;
    n_checks++;
    if (obs !== 14'd0) begin
      n_err++; $display("FAIL mid_mem_async_reset: got %h expected %h", obs, 14'd0);
    end
`ifdef SISC_CTRL_PERF_CNT_EN
    n_checks++;
    if (cyc_cnt !== 4'd0) begin n_err++; $display("FAIL mid_mem_cnt_clear: got %0d expected 0", cyc_cnt); end
`endif
    #1 rst_f = 1'b0;
    m_alu = 2'b00;
    opcode = 4'd0;
    @(negedge clk);
    push_instr(4'd0, 4'd0, 4'd0, 0, 0, 1'b0);
    while (sb.size() != 0) begin
      e = sb.pop_front(); mem_ack = e.ack; n_checks++;
      if (obs !== e.exp) begin n_err++; $display("FAIL mid_mem_refetch: got %h expected %h", obs, e.exp); end
      @(negedge clk);
    end
  endtask

  task automatic test_halt();
    ent_t e;
    opcode = 4'd15; mm = 4'd8; stat = 4'd0;
    push_instr(4'd15, 4'd8, 4'd0, 0, 0, 1'b0);
    for (int i = 0; i < 100; i++) push(1'($urandom_range(0, 1)), ev(6, m_alu, 0, 0, 0, 0, 0, 0, 0, 1));
    while (sb.size() != 0) begin
      e = sb.pop_front(); mem_ack = e.ack; n_checks++;
      if (obs !== e.exp) begin n_err++; $display("FAIL halt_hold: got %h expected %h", obs, e.exp); end
      @(negedge clk);
    end
`ifdef SISC_CTRL_PERF_CNT_EN
    n_checks++;
    if (cyc_cnt !== 4'd5 || instr_cnt !== 4'd2) begin
      n_err++; $display("FAIL halt_cnt_frozen: got %0d/%0d expected 5/2", cyc_cnt, instr_cnt);
    end
`endif
  endtask

`ifdef SISC_CTRL_PERF_CNT_EN
  task automatic test_counters();
    ent_t e;
    rst_f = 1'b1; m_alu = 2'b00; opcode = 4'd0; mm = 4'd0; stat = 4'd0; mem_ack = 1'b1;
    @(negedge clk);
    rst_f = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      push_instr(4'd0, 4'd0, 4'd0, 0, 0, 1'b1);
      while (sb.size() != 0) begin
        e = sb.pop_front(); mem_ack = e.ack; n_checks++;
        if (obs !== e.exp) begin n_err++; $display("FAIL noop_trace: got %h expected %h", obs, e.exp); end
        @(negedge clk);
      end
      if (k == 3) begin
        n_checks++;
        if (cyc_cnt !== 4'd12 || instr_cnt !== 4'd4) begin
          n_err++; $display("FAIL cnt_mid: got %0d/%0d expected 12/4", cyc_cnt, instr_cnt);
        end
      end
    end
    n_checks++;
    if (cyc_cnt !== 4'd15 || instr_cnt !== 4'd15) begin
      n_err++; $display("FAIL cnt_saturate: got %0d/%0d expected 15/15", cyc_cnt, instr_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_lod_wait();
    test_branch();
    test_back_to_back();
    test_reset_mid_mem();
    test_halt();
`ifdef SISC_CTRL_PERF_CNT_EN
    test_counters();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
